// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the debug-port instruction memory loader:
// framing constants, FSM encoding and a ceil-log2 helper.
package instr_mem_loader_pkg;

    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned v;
        int unsigned bits;
        bits = 0;
        v    = value - 1;
        while (v != 0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        return bits;
    endfunction

    localparam int unsigned HEADER_BYTES   = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned NB_BYTE        = 8;
    localparam int unsigned NB_LEN         = HEADER_BYTES * NB_BYTE;
    localparam int unsigned NB_BYTE_CNT    = clogb2(BYTES_PER_WORD);

    typedef enum logic [3:0] {
        ST_LEN_HI    = 4'd0,
        ST_LEN_LO    = 4'd1,
        ST_RX_WORD   = 4'd2,
        ST_WRITE     = 4'd3,
        ST_READ_REQ  = 4'd4,
        ST_READ_WAIT = 4'd5,
        ST_TX_BYTE   = 4'd6,
        ST_DONE      = 4'd7,
        ST_ERROR     = 4'd8
    } state_t;

endpackage

// File: rtl/instr_mem_loader_byte_word_packer.sv
// Byte/word shift register: packs incoming bytes MSB first into a word, or
// serialises a loaded word MSB first. The count wraps after one full word.
module instr_mem_loader_byte_word_packer
    import instr_mem_loader_pkg::*;
#(
    parameter int unsigned NB_WORD = 32
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   load,
    input  logic [NB_WORD-1:0]     load_word,
    input  logic                   shift,
    input  logic [NB_BYTE-1:0]     shift_byte,
    output logic [NB_WORD-1:0]     word,
    output logic [NB_BYTE-1:0]     msb_byte,
    output logic [NB_BYTE_CNT-1:0] count
);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            word  <= '0;
            count <= '0;
        end else if (load) begin
            word  <= load_word;
            count <= '0;
        end else if (shift) begin
            word  <= {word[NB_WORD-NB_BYTE-1:0], shift_byte};
            count <= count + NB_BYTE_CNT'(1);
        end
    end

    assign msb_byte = word[NB_WORD-1 -: NB_BYTE];

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a length-prefixed program from the UART byte stream into instruction
// memory over the debug port, optionally echoes it back, then releases the CPU.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int unsigned N_ADDR      = 2048,
    parameter int unsigned NB_INSTR    = 32,
    parameter int unsigned NB_MEM_ADDR = 16,
    parameter int unsigned READBACK    = 1
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [NB_BYTE-1:0]        i_rx_data,
    input  logic                      i_rx_valid,
    output logic [NB_BYTE-1:0]        o_tx_data,
    output logic                      o_tx_valid,
    input  logic                      i_tx_ready,
    output logic [NB_MEM_ADDR-1:0]    o_mem_addr,
    output logic [NB_INSTR-1:0]       o_mem_data,
    output logic [BYTES_PER_WORD-1:0] o_mem_we,
    output logic                      o_mem_re,
    input  logic [NB_INSTR-1:0]       i_mem_data,
    output logic                      o_cpu_valid,
    output logic                      o_load_done,
    output logic                      o_error
);

    // Index must be able to reach N_ADDR itself after the final increment.
    localparam int unsigned NB_IDX = clogb2(N_ADDR + 1);

    state_t                  state_q, state_d;
    logic [NB_IDX-1:0]       idx_q;
    logic [NB_IDX-1:0]       idx_inc_val;
    logic [NB_LEN-1:0]       len_q;
    logic [NB_LEN-1:0]       header_len;
    logic                    header_bad;
    logic                    idx_last;
    logic                    last_byte;
    logic                    tx_accept;

    logic                    len_hi_ld, len_lo_ld;
    logic                    pk_load, pk_shift;
    logic                    idx_inc, idx_clr;

    logic [NB_INSTR-1:0]     pk_word;
    logic [NB_BYTE-1:0]      pk_msb;
    logic [NB_BYTE_CNT-1:0]  pk_count;

    logic [BYTES_PER_WORD-1:0] we_q;
    logic                      re_q;
    logic                      tx_valid_q;
    logic                      done_q;
    logic                      error_q;

    instr_mem_loader_byte_word_packer #(
        .NB_WORD (NB_INSTR)
    ) u_packer (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .load       (pk_load),
        .load_word  (i_mem_data),
        .shift      (pk_shift),
        .shift_byte (i_rx_data),
        .word       (pk_word),
        .msb_byte   (pk_msb),
        .count      (pk_count)
    );

    assign header_len  = {len_q[NB_LEN-1:NB_BYTE], i_rx_data};
    assign header_bad  = (header_len == '0) || (32'(header_len) > N_ADDR);
    assign idx_inc_val = idx_q + NB_IDX'(1);
    assign idx_last    = (NB_LEN'(idx_inc_val) == len_q);
    assign last_byte   = (pk_count == NB_BYTE_CNT'(BYTES_PER_WORD - 1));
    assign tx_accept   = tx_valid_q && i_tx_ready;

    // State, index and length registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_LEN_HI;
            idx_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            if (idx_clr) begin
                idx_q <= '0;
            end else if (idx_inc) begin
                idx_q <= idx_inc_val;
            end
            if (len_hi_ld) begin
                len_q[NB_LEN-1:NB_BYTE] <= i_rx_data;
            end
            if (len_lo_ld) begin
                len_q[NB_BYTE-1:0] <= i_rx_data;
            end
        end
    end

    // Next-state and datapath controls.
    always_comb begin
        state_d   = state_q;
        len_hi_ld = 1'b0;
        len_lo_ld = 1'b0;
        pk_load   = 1'b0;
        pk_shift  = 1'b0;
        idx_inc   = 1'b0;
        idx_clr   = 1'b0;
        case (state_q)
            ST_LEN_HI: begin
                if (i_rx_valid) begin
                    len_hi_ld = 1'b1;
                    state_d   = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (i_rx_valid) begin
                    len_lo_ld = 1'b1;
                    state_d   = header_bad ? ST_ERROR : ST_RX_WORD;
                end
            end
            ST_RX_WORD: begin
                if (i_rx_valid) begin
                    pk_shift = 1'b1;
                    if (last_byte) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                idx_inc = 1'b1;
                if (idx_last) begin
                    if (READBACK != 0) begin
                        idx_clr = 1'b1;
                        state_d = ST_READ_REQ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_RX_WORD;
                end
            end
            ST_READ_REQ: begin
                state_d = ST_READ_WAIT;
            end
            ST_READ_WAIT: begin
                pk_load = 1'b1;
                state_d = ST_TX_BYTE;
            end
            ST_TX_BYTE: begin
                if (tx_accept) begin
                    pk_shift = 1'b1;
                    if (last_byte) begin
                        idx_inc = 1'b1;
                        state_d = idx_last ? ST_DONE : ST_READ_REQ;
                    end
                end
            end
            ST_DONE:  state_d = ST_DONE;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_LEN_HI;
        endcase
    end

    // Strobes and status are registered from the next state so they line up with it.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            we_q       <= '0;
            re_q       <= 1'b0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            we_q       <= (state_d == ST_WRITE) ? {BYTES_PER_WORD{1'b1}} : '0;
            re_q       <= (state_d == ST_WRITE) || (state_d == ST_READ_REQ);
            tx_valid_q <= (state_d == ST_TX_BYTE);
            done_q     <= (state_d == ST_DONE);
            error_q    <= (state_d == ST_ERROR);
        end
    end

    assign o_mem_addr  = NB_MEM_ADDR'(idx_q);
    assign o_mem_data  = pk_word;
    assign o_mem_we    = we_q;
    assign o_mem_re    = re_q;
    assign o_tx_data   = pk_msb;
    assign o_tx_valid  = tx_valid_q;
    assign o_load_done = done_q;
    assign o_cpu_valid = done_q;
    assign o_error     = error_q;

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Debug-side writer for the instruction memory's second port. It takes a byte stream from the UART receiver, parses a length header and then the program words, and writes each word into instruction memory through the debug address/data/write-enable port. It can optionally read every word back and stream it out as bytes to the UART transmitter. It holds the CPU pipeline invalid until the load (and readback) has completed.

Parameters:
N_ADDR, 2048, instruction memory depth in words; the largest legal program length.
NB_INSTR, 32, instruction word width.
NB_MEM_ADDR, 16, width of the debug word address.
READBACK, 1, 1 = read back and transmit all words after loading; 0 = skip readback.

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_rx_data  in  8  received byte
i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid
o_tx_data  out  8  byte to transmit
o_tx_valid  out  1  o_tx_data is valid; held until accepted
i_tx_ready  in  1  transmitter accepts the byte when o_tx_valid && i_tx_ready
o_mem_addr  out  NB_MEM_ADDR  instruction memory debug word address
o_mem_data  out  NB_INSTR  write data
o_mem_we  out  4  byte write enables
o_mem_re  out  1  debug port enable/read strobe
i_mem_data  in  NB_INSTR  debug port read data; valid 1 cycle after o_mem_re
o_cpu_valid  out  1  CPU pipeline valid/enable
o_load_done  out  1  program loaded (and verified, if READBACK)
o_error  out  1  bad length header

Behaviour:
- Reset values: all outputs 0. Internal state: LEN_HI, word index 0, byte count 0. Reset mid-operation aborts the load immediately and forces the same values. Words already written remain in memory.
- Framing: 2-byte length N (MSB first), then N words of 4 bytes each, each word MSB first (byte 0 goes to bits [31:24]).
- States:
  - LEN_HI: take a byte on i_rx_valid → LEN_LO.
  - LEN_LO: take a byte. If N==0 or N>N_ADDR → ERROR; otherwise → RX_WORD.
  - RX_WORD: shift bytes in. On the 4th byte → WRITE.
  - WRITE: exactly one cycle with o_mem_we=4'hF, o_mem_re=1, o_mem_addr=idx, o_mem_data=assembled word.
    - o_mem_re is asserted during writes because the port enable is not guaranteed for all-zero data.
    - Then idx++. If idx==N: → READ_REQ with idx=0 if READBACK, else → DONE. Otherwise → RX_WORD.
  - READ_REQ: one cycle, o_mem_re=1, o_mem_we=0, o_mem_addr=idx → READ_WAIT.
  - READ_WAIT: capture i_mem_data into the tx shift register → TX_BYTE.
  - TX_BYTE: o_tx_valid=1 with the MSB byte. On i_tx_ready, shift. After 4 accepted bytes, idx++. If idx==N → DONE, else → READ_REQ.
  - DONE: o_load_done=1 and o_cpu_valid=1, held until reset. Further rx bytes are ignored.
  - ERROR: o_error=1 and o_cpu_valid=0, held until reset. Rx bytes are ignored.
- Rx timing: a new i_rx_valid strobe arriving during WRITE, READ_REQ, READ_WAIT or TX_BYTE is dropped. The UART byte period guarantees none arrives during WRITE in normal operation.
- o_mem_we and o_mem_re are 0 in every state not listed above. o_mem_addr is zero-extended from the word index.
- o_tx_data/o_tx_valid must not change while o_tx_valid=1 and i_tx_ready=0. The transmit handshake has no timeout.
- Address boundary: the last legal word address is N_ADDR-1. The index never exceeds N-1 at a write.
- Latency: last rx byte to write strobe is 1 cycle. o_mem_re to data capture is 1 cycle.

Decomposition:
- Shared package holds: state encoding localparams, the header byte count (2), BYTES_PER_WORD=4, and the clogb2 function.
- One natural sub-module, byte_word_packer: assembles 4 bytes into a word and serialises a word back into 4 bytes. It has load/shift controls and a count output.
- The FSM and index counter stay in the top level.

Test Plan:
1. Stream 00 02 | DE AD BE EF | 00 00 00 00, READBACK=1 → writes:
   - addr 0 data 0xDEADBEEF with we=F, re=1;
   - addr 1 data 0x00000000 with we=F, re=1;
   - then tx bytes DE AD BE EF 00 00 00 00;
   - then o_load_done=o_cpu_valid=1.
2. Hold i_tx_ready=0 for 10 cycles in the middle of readback → o_tx_data is stable, no byte is lost, and the byte order is unchanged.
3. Header 00 00 → o_error=1, no o_mem_we pulse, o_cpu_valid stays 0. Header 08 01 (2049) with N_ADDR=2048 → same result.
4. Load N=N_ADDR words with READBACK=0 → last write at addr 0x07FF, no tx activity, DONE.
5. Assert i_reset after 2 bytes of word 1 → all outputs 0. A fresh header then restarts the load at addr 0.
6. Send 5 extra bytes after DONE → no memory writes, outputs unchanged.
